// File: rtl/serial_dispatch_4way_chip_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_dispatch_4way_chip_if
// Description : Word-in / serial-out bundle for the 4-way demux feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_dispatch_4way_chip_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_chan;
  logic             out_bit;
  logic [1:0]       out_sel;
  logic             out_valid;
  logic             busy;

  modport master (
    output in_valid, in_data, in_chan,
    input  in_ready, out_bit, out_sel, out_valid, busy
  );

  modport slave (
    input  in_valid, in_data, in_chan,
    output in_ready, out_bit, out_sel, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_dispatch_4way_chip.sv
`default_nettype none
// ============================================================================
// Module      : serial_dispatch_4way_chip
// Description : FIFO-buffered LSB-first serializer feeding a 4-way 1-bit demux.
//               Define DISPATCH_PARITY_EN to append an even-parity bit per word.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_dispatch_4way_chip #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  serial_dispatch_4way_chip_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1
`ifdef DISPATCH_PARITY_EN
    ,S_PARITY = 2'd2
`endif
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH+1:0]   r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      w_count;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_last;
  logic [WIDTH+1:0]   w_head;
  logic [WIDTH-1:0]   r_shift;
  logic [1:0]         r_sel;
  logic [CW-1:0]      r_cnt;
`ifdef DISPATCH_PARITY_EN
  logic               r_par;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == PW'(DEPTH));
  assign w_push  = bus.in_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
`ifdef DISPATCH_PARITY_EN
          w_next = S_PARITY;
`else
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
`endif
        end
      end
`ifdef DISPATCH_PARITY_EN
      S_PARITY: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_SHIFT;
        end else begin
          w_next = S_IDLE;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = !w_full;
    bus.busy      = (r_state != S_IDLE) || !w_empty;
    bus.out_valid = (r_state != S_IDLE);
    bus.out_sel   = (r_state != S_IDLE) ? r_sel : 2'b00;
    bus.out_bit   = 1'b0;
    case (r_state)
      S_SHIFT:    bus.out_bit = r_shift[0];
`ifdef DISPATCH_PARITY_EN
      S_PARITY:   bus.out_bit = r_par;
`endif
      default:    bus.out_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {bus.in_chan, bus.in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_shift  <= '0;
      r_sel    <= 2'b00;
      r_cnt    <= '0;
`ifdef DISPATCH_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_shift  <= w_head[WIDTH-1:0];
        r_sel    <= w_head[WIDTH+1:WIDTH];
        r_cnt    <= '0;
`ifdef DISPATCH_PARITY_EN
        r_par    <= ^w_head[WIDTH-1:0];
`endif
      end else if (r_state == S_SHIFT) begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_serial_dispatch_4way_chip.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_dispatch_4way_chip
// Description : Directed bench for the serial 4-way dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_dispatch_4way_chip;
  localparam int WIDTH = 8;
`ifdef DISPATCH_PARITY_EN
  localparam int WPC = WIDTH + 1;
`else
  localparam int WPC = WIDTH;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_dispatch_4way_chip_if #(.WIDTH(WIDTH)) bus ();

  serial_dispatch_4way_chip #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [WIDTH-1:0] wd [4];
  logic [1:0]       wc [4];
  logic             rx_bit [64];
  logic [1:0]       rx_sel [64];
  logic             rdy_hist [40];
  int               nrx;
  int               idx;
  int               vc;
  logic             acc;
  logic [WIDTH-1:0] rw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_bit"},   bus.out_bit,   0);
    chk({tag, "_sel"},   bus.out_sel,   0);
    chk({tag, "_busy"},  bus.busy,      0);
    chk({tag, "_ready"}, bus.in_ready,  1);
  endtask

  task automatic expect_word(input logic [WIDTH-1:0] d, input logic [1:0] c, input string tag);
    for (int i = 0; i < WIDTH; i++) begin
      chk($sformatf("%s_bit%0d", tag, i),   bus.out_bit,   d[i]);
      chk($sformatf("%s_sel%0d", tag, i),   bus.out_sel,   c);
      chk($sformatf("%s_valid%0d", tag, i), bus.out_valid, 1);
      tick();
    end
`ifdef DISPATCH_PARITY_EN
    chk({tag, "_parity"},  bus.out_bit,   ^d);
    chk({tag, "_psel"},    bus.out_sel,   c);
    chk({tag, "_pvalid"},  bus.out_valid, 1);
    tick();
`endif
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_chan  = 2'd3;

    // Reset with a write attempt that must be ignored.
    tick();
    tick();
    chk_idle("reset");
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    chk_idle("post_reset");

    // Single word, latency and idle afterwards.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    bus.in_chan  = 2'd2;
    tick();
    chk("a5_wait_valid", bus.out_valid, 0);
    chk("a5_wait_busy",  bus.busy,      1);
    chk("a5_wait_ready", bus.in_ready,  1);
    bus.in_valid = 1'b0;
    tick();
    expect_word(8'hA5, 2'd2, "a5");
    chk_idle("a5_done");

    // Back-to-back; second push coincides with first pop.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_chan  = 2'd1;
    tick();
    bus.in_data  = 8'h01;
    bus.in_chan  = 2'd3;
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_ready", bus.in_ready, 1);
    expect_word(8'hFF, 2'd1, "ff");
    expect_word(8'h01, 2'd3, "w01");
    chk_idle("b2b_done");

    // Backpressure with in_valid held.
    wd[0] = 8'hC3; wc[0] = 2'd0;
    wd[1] = 8'h5A; wc[1] = 2'd1;
    wd[2] = 8'h81; wc[2] = 2'd2;
    wd[3] = 8'h7E; wc[3] = 2'd3;
    idx = 0;
    nrx = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = wd[0];
    bus.in_chan  = wc[0];
    for (int k = 0; k < 40; k++) begin
      acc         = bus.in_valid && bus.in_ready;
      rdy_hist[k] = bus.in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) begin
          bus.in_data = wd[idx];
          bus.in_chan = wc[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid && nrx < 64) begin
        rx_bit[nrx] = bus.out_bit;
        rx_sel[nrx] = bus.out_sel;
        nrx++;
      end
    end
    chk("bp_ready_k2",   rdy_hist[2],       1);
    chk("bp_ready_drop", rdy_hist[3],       0);
    chk("bp_ready_hold", rdy_hist[1 + WPC], 0);
    chk("bp_ready_rise", rdy_hist[2 + WPC], 1);
    chk("bp_accepted",   idx,               4);
    chk("bp_nbits",      nrx,               4 * WPC);
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < WIDTH; i++) rw[i] = rx_bit[w * WPC + i];
      chk($sformatf("bp_word%0d", w),     rw,                            wd[w]);
      chk($sformatf("bp_sel_first%0d", w), rx_sel[w * WPC],              wc[w]);
      chk($sformatf("bp_sel_last%0d", w),  rx_sel[w * WPC + WPC - 1],    wc[w]);
`ifdef DISPATCH_PARITY_EN
      chk($sformatf("bp_par%0d", w),       rx_bit[w * WPC + WIDTH],      ^wd[w]);
`endif
    end
    chk_idle("bp_done");

    // Parity vectors (plain words when parity is off).
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h07;
    bus.in_chan  = 2'd0;
    tick();
    bus.in_data  = 8'h03;
    tick();
    bus.in_valid = 1'b0;
    expect_word(8'h07, 2'd0, "w07");
    expect_word(8'h03, 2'd0, "w03");
    chk_idle("par_done");

    // Reset asserted mid-word, while bit 4 of 8'h3C is on the wire.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    bus.in_chan  = 2'd1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    repeat (4) tick();
    chk("mid_bit4", bus.out_bit, 1);
    chk("mid_sel",  bus.out_sel, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    tick();
    rst_n = 1'b1;
    vc = 0;
    repeat (12) begin
      tick();
      if (bus.out_valid) vc++;
    end
    chk("post_abort_valid_cycles", vc, 0);
    chk_idle("post_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
